// File: rtl/div_arbiter.sv
// -----------------------------------------------------------------------------
// div_arbiter
//   Round-robin arbiter sharing one bit-serial divider among N_REQ requesters.
//   One job is in flight at a time: the winning request's operands are latched,
//   the divider is started, and its result goes back to the owning requester
//   as a one-cycle strobe. Divide-by-zero is answered locally without touching
//   the divider. A divider that does not finish within TIMEOUT wait cycles
//   gets an error response, and the arbiter then waits for it to return to
//   idle before it accepts new work.
//
// Ports
//   CLK             clock, all logic on posedge
//   reset           synchronous, active-low reset
//   req_valid       per-requester job request (operands stable while high)
//   req_dividend    packed dividends, requester k in [k*DATA_W +: DATA_W]
//   req_divisor     packed divisors, same packing
//   req_ready       one-hot accept (combinational, IDLE and div_idle only)
//   resp_valid      one-hot, one-cycle response strobe to the job owner
//   resp_quotient   quotient, zero when resp_valid is 0
//   resp_remainder  remainder, zero when resp_valid is 0
//   resp_div_zero   job had divisor == 0
//   resp_timeout    divider did not finish in time
//   div_start       one-cycle start pulse to the divider
//   div_dividend    latched dividend, held until the next accept
//   div_divisor     latched divisor, held until the next accept
//   div_idle        divider is in its idle state
//   div_finish      divider result valid this cycle
//   div_quotient    divider quotient
//   div_remainder   divider remainder
//
// States
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | waiting for a request; req_ready driven when div_idle
//   S_ISSUE | div_start high for this one cycle, wait timer loaded
//   S_WAIT  | waiting for div_finish or the wait timer to expire
//   S_RESP  | resp_valid strobe with registered result and flags
//   S_DRAIN | after a timeout, wait for the divider to report idle
// -----------------------------------------------------------------------------
module div_arbiter #(
    parameter int N_REQ   = 4,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                    CLK,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_dividend,
    input  logic [N_REQ*DATA_W-1:0] req_divisor,
    output logic [N_REQ-1:0]        req_ready,
    output logic [N_REQ-1:0]        resp_valid,
    output logic [DATA_W-1:0]       resp_quotient,
    output logic [DATA_W-1:0]       resp_remainder,
    output logic                    resp_div_zero,
    output logic                    resp_timeout,
    output logic                    div_start,
    output logic [DATA_W-1:0]       div_dividend,
    output logic [DATA_W-1:0]       div_divisor,
    input  logic                    div_idle,
    input  logic                    div_finish,
    input  logic [DATA_W-1:0]       div_quotient,
    input  logic [DATA_W-1:0]       div_remainder
);

    localparam int GW = $clog2(N_REQ);
    localparam int SW = GW + 1;
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_RESP  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t            state;
    logic [GW-1:0]     last_grant;
    logic [GW-1:0]     owner;
    logic [TW-1:0]     timer;

    logic              found;
    logic [GW-1:0]     grant_idx;
    logic [N_REQ-1:0]  grant_oh;
    logic              accept;
    logic [DATA_W-1:0] sel_dividend;
    logic [DATA_W-1:0] sel_divisor;

    function automatic logic [N_REQ-1:0] onehot(input logic [GW-1:0] idx);
        logic [N_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Circular search starting just after last_grant; the sum is one bit wider
    // than an index so the wrap works for non-power-of-two N_REQ as well.
    always_comb begin
        logic [SW-1:0] sum;
        logic [GW-1:0] idx;
        sum       = '0;
        idx       = '0;
        found     = 1'b0;
        grant_idx = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            sum = {1'b0, last_grant} + SW'(i);
            if (sum >= SW'(N_REQ)) begin
                sum = sum - SW'(N_REQ);
            end
            idx = sum[GW-1:0];
            if (!found && req_valid[idx]) begin
                found     = 1'b1;
                grant_idx = idx;
            end
        end
    end

    always_comb begin
        sel_dividend = '0;
        sel_divisor  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (grant_idx == GW'(k)) begin
                sel_dividend = req_dividend[k*DATA_W +: DATA_W];
                sel_divisor  = req_divisor[k*DATA_W +: DATA_W];
            end
        end
    end

    assign accept    = (state == S_IDLE) && div_idle && found;
    assign grant_oh  = onehot(grant_idx);
    assign req_ready = accept ? grant_oh : '0;

    // Outputs are registered so that div_start lines up with S_ISSUE and
    // resp_* line up with S_RESP; every strobe and response field defaults
    // to zero so it reads back zero outside its one cycle.
    always_ff @(posedge CLK) begin
        if (!reset) begin
            state          <= S_IDLE;
            last_grant     <= GW'(N_REQ - 1);
            owner          <= '0;
            timer          <= '0;
            div_start      <= 1'b0;
            div_dividend   <= '0;
            div_divisor    <= '0;
            resp_valid     <= '0;
            resp_quotient  <= '0;
            resp_remainder <= '0;
            resp_div_zero  <= 1'b0;
            resp_timeout   <= 1'b0;
        end else begin
            div_start      <= 1'b0;
            resp_valid     <= '0;
            resp_quotient  <= '0;
            resp_remainder <= '0;
            resp_div_zero  <= 1'b0;
            resp_timeout   <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (accept) begin
                        owner        <= grant_idx;
                        last_grant   <= grant_idx;
                        div_dividend <= sel_dividend;
                        div_divisor  <= sel_divisor;
                        if (sel_divisor == '0) begin
                            state          <= S_RESP;
                            resp_valid     <= grant_oh;
                            resp_div_zero  <= 1'b1;
                            resp_remainder <= sel_dividend;
                        end else begin
                            state     <= S_ISSUE;
                            div_start <= 1'b1;
                        end
                    end
                end

                // Down-counter: expires when it reaches zero on the
                // TIMEOUT-th wait cycle.
                S_ISSUE: begin
                    timer <= TW'(TIMEOUT - 1);
                    state <= S_WAIT;
                end

                S_WAIT: begin
                    if (div_finish) begin
                        state          <= S_RESP;
                        resp_valid     <= onehot(owner);
                        resp_quotient  <= div_quotient;
                        resp_remainder <= div_remainder;
                    end else if (timer == '0) begin
                        state        <= S_RESP;
                        resp_valid   <= onehot(owner);
                        resp_timeout <= 1'b1;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end

                // resp_timeout still holds this job's flag here.
                S_RESP: begin
                    state <= resp_timeout ? S_DRAIN : S_IDLE;
                end

                S_DRAIN: begin
                    if (div_idle) begin
                        state <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_arbiter.sv
module tb_div_arbiter;

    localparam int N_REQ   = 4;
    localparam int DATA_W  = 8;
    localparam int TIMEOUT = 64;

    logic                    CLK = 1'b0;
    logic                    reset = 1'b0;
    logic [N_REQ-1:0]        req_valid = '0;
    logic [N_REQ*DATA_W-1:0] req_dividend = '0;
    logic [N_REQ*DATA_W-1:0] req_divisor = '0;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ-1:0]        resp_valid;
    logic [DATA_W-1:0]       resp_quotient;
    logic [DATA_W-1:0]       resp_remainder;
    logic                    resp_div_zero;
    logic                    resp_timeout;
    logic                    div_start;
    logic [DATA_W-1:0]       div_dividend;
    logic [DATA_W-1:0]       div_divisor;
    logic                    div_idle = 1'b1;
    logic                    div_finish = 1'b0;
    logic [DATA_W-1:0]       div_quotient = '0;
    logic [DATA_W-1:0]       div_remainder = '0;

    int checks   = 0;
    int failures = 0;

    // Fairness operands and their hand-computed results per requester.
    logic [7:0] t2_dvd [4] = '{8'd200, 8'd13, 8'd255, 8'd7};
    logic [7:0] t2_dvs [4] = '{8'd9,   8'd5,  8'd16,  8'd8};
    logic [7:0] t2_q   [4] = '{8'd22,  8'd2,  8'd15,  8'd0};
    logic [7:0] t2_r   [4] = '{8'd2,   8'd3,  8'd15,  8'd7};

    div_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .CLK            (CLK),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_dividend   (req_dividend),
        .req_divisor    (req_divisor),
        .req_ready      (req_ready),
        .resp_valid     (resp_valid),
        .resp_quotient  (resp_quotient),
        .resp_remainder (resp_remainder),
        .resp_div_zero  (resp_div_zero),
        .resp_timeout   (resp_timeout),
        .div_start      (div_start),
        .div_dividend   (div_dividend),
        .div_divisor    (div_divisor),
        .div_idle       (div_idle),
        .div_finish     (div_finish),
        .div_quotient   (div_quotient),
        .div_remainder  (div_remainder)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic set_op(input int k, input logic [7:0] a, input logic [7:0] b);
        req_dividend[k*DATA_W +: DATA_W] = a;
        req_divisor[k*DATA_W +: DATA_W]  = b;
    endtask

    task automatic do_reset();
        reset      = 1'b0;
        req_valid  = '0;
        div_idle   = 1'b1;
        div_finish = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
    endtask

    // Plays the divider from the ISSUE cycle: finish is raised on wait
    // cycle 'lat' (0-based); returns at the negedge of the RESP cycle.
    task automatic serve(input int lat, input logic [7:0] q, input logic [7:0] r);
        tick();
        div_idle = 1'b0;
        repeat (lat) tick();
        div_finish    = 1'b1;
        div_quotient  = q;
        div_remainder = r;
        tick();
        div_finish    = 1'b0;
        div_quotient  = '0;
        div_remainder = '0;
        div_idle      = 1'b1;
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        req_valid = 4'b1111;
        repeat (2) tick();
        #1;
        checks++;
        if (resp_valid !== 4'b0000 || resp_quotient !== 8'd0 || resp_remainder !== 8'd0) begin
            failures++;
            $display("FAIL reset_resp got valid=%b q=%0d r=%0d exp 0", resp_valid, resp_quotient, resp_remainder);
        end
        checks++;
        if (div_start !== 1'b0 || div_dividend !== 8'd0 || div_divisor !== 8'd0
            || resp_div_zero !== 1'b0 || resp_timeout !== 1'b0) begin
            failures++;
            $display("FAIL reset_div got start=%b dvd=%0d dvs=%0d dz=%b to=%b exp 0",
                     div_start, div_dividend, div_divisor, resp_div_zero, resp_timeout);
        end
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL reset_priority got=%b exp=0001", req_ready);
        end
        req_valid = '0;
        reset     = 1'b1;
    endtask

    task automatic test_single_job();
        set_op(0, 8'd100, 8'd7);
        req_valid = 4'b0001;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL t1_ready got=%b exp=0001", req_ready);
        end
        tick();
        checks++;
        if (div_start !== 1'b1 || div_dividend !== 8'd100 || div_divisor !== 8'd7) begin
            failures++;
            $display("FAIL t1_issue got start=%b dvd=%0d dvs=%0d exp 1/100/7", div_start, div_dividend, div_divisor);
        end
        req_valid = '0;
        tick();
        checks++;
        if (div_start !== 1'b0) begin
            failures++;
            $display("FAIL t1_start_pulse got=%b exp=0", div_start);
        end
        div_idle = 1'b0;
        repeat (3) tick();
        div_finish    = 1'b1;
        div_quotient  = 8'd14;
        div_remainder = 8'd2;
        tick();
        div_finish = 1'b0;
        div_idle   = 1'b1;
        checks++;
        if (resp_valid !== 4'b0001 || resp_quotient !== 8'd14 || resp_remainder !== 8'd2
            || resp_div_zero !== 1'b0 || resp_timeout !== 1'b0) begin
            failures++;
            $display("FAIL t1_resp got v=%b q=%0d r=%0d dz=%b to=%b exp 0001/14/2/0/0",
                     resp_valid, resp_quotient, resp_remainder, resp_div_zero, resp_timeout);
        end
        tick();
        checks++;
        if (resp_valid !== 4'b0000 || resp_quotient !== 8'd0 || resp_remainder !== 8'd0) begin
            failures++;
            $display("FAIL t1_resp_clear got v=%b q=%0d r=%0d exp 0", resp_valid, resp_quotient, resp_remainder);
        end
    endtask

    task automatic test_fairness();
        do_reset();
        for (int k = 0; k < 4; k++) set_op(k, t2_dvd[k], t2_dvs[k]);
        req_valid = 4'b1111;
        #1;
        for (int j = 0; j < 16; j++) begin
            int k;
            k = j % 4;
            checks++;
            if (req_ready !== (4'b0001 << k)) begin
                failures++;
                $display("FAIL t2_grant job=%0d got=%b exp=%b", j, req_ready, 4'b0001 << k);
            end
            tick();
            checks++;
            if (div_start !== 1'b1 || div_dividend !== t2_dvd[k] || div_divisor !== t2_dvs[k]) begin
                failures++;
                $display("FAIL t2_issue job=%0d got start=%b dvd=%0d dvs=%0d exp 1/%0d/%0d",
                         j, div_start, div_dividend, div_divisor, t2_dvd[k], t2_dvs[k]);
            end
            serve(1, t2_q[k], t2_r[k]);
            checks++;
            if (resp_valid !== (4'b0001 << k) || resp_quotient !== t2_q[k] || resp_remainder !== t2_r[k]) begin
                failures++;
                $display("FAIL t2_resp job=%0d got v=%b q=%0d r=%0d exp %b/%0d/%0d",
                         j, resp_valid, resp_quotient, resp_remainder, 4'b0001 << k, t2_q[k], t2_r[k]);
            end
            if (j == 15) req_valid = '0;
            tick();
            #1;
        end
    endtask

    task automatic test_zero_divisor();
        set_op(2, 8'd55, 8'd0);
        req_valid = 4'b0100;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            failures++;
            $display("FAIL t3_ready got=%b exp=0100", req_ready);
        end
        tick();
        req_valid = '0;
        checks++;
        if (div_start !== 1'b0) begin
            failures++;
            $display("FAIL t3_no_start got=%b exp=0", div_start);
        end
        checks++;
        if (resp_valid !== 4'b0100 || resp_div_zero !== 1'b1 || resp_quotient !== 8'd0
            || resp_remainder !== 8'd55 || resp_timeout !== 1'b0) begin
            failures++;
            $display("FAIL t3_resp got v=%b dz=%b q=%0d r=%0d to=%b exp 0100/1/0/55/0",
                     resp_valid, resp_div_zero, resp_quotient, resp_remainder, resp_timeout);
        end
        tick();
        checks++;
        if (resp_valid !== 4'b0000 || resp_div_zero !== 1'b0 || resp_remainder !== 8'd0) begin
            failures++;
            $display("FAIL t3_clear got v=%b dz=%b r=%0d exp 0", resp_valid, resp_div_zero, resp_remainder);
        end
    endtask

    task automatic test_timeout();
        set_op(1, 8'd9, 8'd3);
        req_valid = 4'b0010;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            failures++;
            $display("FAIL t4_ready got=%b exp=0010", req_ready);
        end
        tick();
        req_valid = '0;
        checks++;
        if (div_start !== 1'b1) begin
            failures++;
            $display("FAIL t4_start got=%b exp=1", div_start);
        end
        tick();
        div_idle = 1'b0;
        repeat (TIMEOUT - 1) tick();
        checks++;
        if (resp_valid !== 4'b0000) begin
            failures++;
            $display("FAIL t4_early got=%b exp=0000", resp_valid);
        end
        tick();
        checks++;
        if (resp_valid !== 4'b0010 || resp_timeout !== 1'b1 || resp_div_zero !== 1'b0
            || resp_quotient !== 8'd0 || resp_remainder !== 8'd0) begin
            failures++;
            $display("FAIL t4_resp got v=%b to=%b dz=%b q=%0d r=%0d exp 0010/1/0/0/0",
                     resp_valid, resp_timeout, resp_div_zero, resp_quotient, resp_remainder);
        end
        tick();
        set_op(0, 8'd20, 8'd4);
        req_valid = 4'b0001;
        #1;
        checks++;
        if (req_ready !== 4'b0000) begin
            failures++;
            $display("FAIL t4_drain_hold got=%b exp=0000", req_ready);
        end
        repeat (3) tick();
        div_idle = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0000) begin
            failures++;
            $display("FAIL t4_drain_exit got=%b exp=0000", req_ready);
        end
        tick();
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL t4_after_drain got=%b exp=0001", req_ready);
        end
        tick();
        req_valid = '0;
        checks++;
        if (div_start !== 1'b1 || div_dividend !== 8'd20 || div_divisor !== 8'd4) begin
            failures++;
            $display("FAIL t4_next_issue got start=%b dvd=%0d dvs=%0d exp 1/20/4", div_start, div_dividend, div_divisor);
        end
        serve(3, 8'd5, 8'd0);
        checks++;
        if (resp_valid !== 4'b0001 || resp_quotient !== 8'd5 || resp_remainder !== 8'd0 || resp_timeout !== 1'b0) begin
            failures++;
            $display("FAIL t4_next_resp got v=%b q=%0d r=%0d to=%b exp 0001/5/0/0",
                     resp_valid, resp_quotient, resp_remainder, resp_timeout);
        end
        tick();
    endtask

    task automatic test_coincidence();
        set_op(3, 8'd77, 8'd6);
        req_valid = 4'b1000;
        #1;
        checks++;
        if (req_ready !== 4'b1000) begin
            failures++;
            $display("FAIL t5_ready got=%b exp=1000", req_ready);
        end
        tick();
        req_valid = '0;
        serve(TIMEOUT - 1, 8'd12, 8'd5);
        checks++;
        if (resp_valid !== 4'b1000 || resp_quotient !== 8'd12 || resp_remainder !== 8'd5
            || resp_timeout !== 1'b0 || resp_div_zero !== 1'b0) begin
            failures++;
            $display("FAIL t5_resp got v=%b q=%0d r=%0d to=%b dz=%b exp 1000/12/5/0/0",
                     resp_valid, resp_quotient, resp_remainder, resp_timeout, resp_div_zero);
        end
        tick();
        set_op(0, 8'd1, 8'd1);
        req_valid = 4'b0001;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL t5_back_to_idle got=%b exp=0001", req_ready);
        end
        req_valid = '0;
        #1;
    endtask

    task automatic test_reset_mid_wait();
        int stray;
        stray = 0;
        set_op(2, 8'd40, 8'd5);
        req_valid = 4'b0100;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            failures++;
            $display("FAIL t6_ready got=%b exp=0100", req_ready);
        end
        tick();
        req_valid = '0;
        tick();
        div_idle = 1'b0;
        repeat (5) tick();
        reset = 1'b0;
        tick();
        checks++;
        if (div_start !== 1'b0 || div_dividend !== 8'd0 || div_divisor !== 8'd0 || resp_valid !== 4'b0000
            || resp_timeout !== 1'b0 || resp_div_zero !== 1'b0) begin
            failures++;
            $display("FAIL t6_outputs got start=%b dvd=%0d dvs=%0d v=%b to=%b dz=%b exp 0",
                     div_start, div_dividend, div_divisor, resp_valid, resp_timeout, resp_div_zero);
        end
        reset    = 1'b1;
        div_idle = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (resp_valid !== 4'b0000) stray++;
        end
        checks++;
        if (stray != 0) begin
            failures++;
            $display("FAIL t6_no_resp got=%0d strobes exp=0", stray);
        end
        set_op(0, 8'd3, 8'd1);
        set_op(1, 8'd3, 8'd1);
        req_valid = 4'b0111;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL t6_priority got=%b exp=0001", req_ready);
        end
        req_valid = '0;
        #1;
    endtask

    initial begin
        tick();
        test_reset();
        test_single_job();
        test_fairness();
        test_zero_divisor();
        test_timeout();
        test_coincidence();
        test_reset_mid_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
